// File: rtl/frame_buffer_scheduler.sv
// Packs camera pixel tokens into PSRAM write bursts, arbitrates them against display reads,
// and ping-pongs frame buffers. Define FB_SCHED_STATS_EN to enable the dropped-token counter.
module frame_buffer_scheduler #(
  parameter int unsigned           FRAME_WIDTH  = 640,
  parameter int unsigned           FRAME_HEIGHT = 480,
  parameter int unsigned           BURST_LEN    = 16,
  parameter int unsigned           ADDR_WIDTH   = 21,
  parameter logic [ADDR_WIDTH-1:0] FRAME0_BASE  = ADDR_WIDTH'(21'h000000),
  parameter logic [ADDR_WIDTH-1:0] FRAME1_BASE  = ADDR_WIDTH'(21'h080000)
) (
  input  logic                         MemClk,
  input  logic                         RST,
  input  logic [16:0]                  queue_data,
  input  logic                         queue_empty,
  output logic                         queue_rd_en,
  output logic                         mem_cmd_valid,
  input  logic                         mem_cmd_ready,
  output logic                         mem_cmd_write,
  output logic [ADDR_WIDTH-1:0]        mem_cmd_addr,
  output logic [$clog2(BURST_LEN):0]   mem_cmd_len,
  output logic [15:0]                  mem_wdata,
  output logic                         mem_wdata_valid,
  input  logic                         mem_wdata_ready,
  input  logic                         rd_req_valid,
  input  logic [ADDR_WIDTH-1:0]        rd_req_offset,
  input  logic [$clog2(BURST_LEN):0]   rd_req_len,
  output logic                         rd_req_ready,
  output logic                         frame_swap,
  output logic                         display_buf,
  output logic [15:0]                  drop_count
);

  localparam int unsigned LEN_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned IDX_W = $clog2(BURST_LEN);
  localparam int unsigned COL_W = $clog2(FRAME_WIDTH + 1);
  localparam logic [LEN_W-1:0]      BLEN     = LEN_W'(BURST_LEN);
  localparam logic [COL_W-1:0]      FWID     = COL_W'(FRAME_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH);

  if ((FRAME_WIDTH % BURST_LEN) != 0 || FRAME_HEIGHT == 0) begin : g_cfg_check
    $error("frame_buffer_scheduler: FRAME_WIDTH must be a multiple of BURST_LEN");
  end

  typedef enum logic [1:0] {ARB_IDLE, ISSUE_WR, STREAM_WR, ISSUE_RD} arb_state_t;

  arb_state_t              state;
  logic                    wr_buf;
  logic                    frame_active;
  logic                    first_row;
  logic [ADDR_WIDTH-1:0]   row_base;
  logic [COL_W-1:0]        col;
  logic [LEN_W-1:0]        count;
  logic [ADDR_WIDTH-1:0]   start_addr;
  logic                    flush_pend;
  logic                    swap_pend;
  logic                    last_grant_wr;
  logic [LEN_W-1:0]        idx;
  logic [15:0]             pbuf [BURST_LEN];

  logic                    is_ctrl;
  logic                    px_take;
  logic                    wd_fire;
  logic                    last_word;
  logic [LEN_W-1:0]        idx_nxt;
  logic [ADDR_WIDTH-1:0]   wr_base;
  logic [ADDR_WIDTH-1:0]   disp_base;

  always_comb begin
    queue_rd_en  = !queue_empty && (count < BLEN) && !flush_pend;
    is_ctrl      = queue_data[16];
    px_take      = queue_rd_en && !is_ctrl && frame_active && (col < FWID);
    wd_fire      = mem_wdata_valid && mem_wdata_ready;
    idx_nxt      = idx + LEN_W'(1);
    last_word    = (idx_nxt == mem_cmd_len);
    wr_base      = wr_buf ? FRAME1_BASE : FRAME0_BASE;
    disp_base    = display_buf ? FRAME1_BASE : FRAME0_BASE;
    rd_req_ready = (state == ISSUE_RD) && mem_cmd_ready;
  end

  always_ff @(posedge MemClk) begin
    if (px_take) pbuf[count[IDX_W-1:0]] <= queue_data[15:0];
  end

  // Intake stalls whenever a flush is pending, so the buffer and its fill count
  // are stable from the moment a burst is requested until its last word streams out.
  always_ff @(posedge MemClk or posedge RST) begin
    if (RST) begin
      state           <= ARB_IDLE;
      wr_buf          <= 1'b0;
      display_buf     <= 1'b1;
      frame_swap      <= 1'b0;
      frame_active    <= 1'b0;
      first_row       <= 1'b0;
      row_base        <= '0;
      col             <= '0;
      count           <= '0;
      start_addr      <= '0;
      flush_pend      <= 1'b0;
      swap_pend       <= 1'b0;
      last_grant_wr   <= 1'b1;
      idx             <= '0;
      mem_cmd_valid   <= 1'b0;
      mem_cmd_write   <= 1'b0;
      mem_cmd_addr    <= '0;
      mem_cmd_len     <= '0;
      mem_wdata       <= '0;
      mem_wdata_valid <= 1'b0;
    end else begin
      frame_swap <= 1'b0;

      if (queue_rd_en) begin
        if (is_ctrl) begin
          case (queue_data[15:0])
            16'h0000: begin
              frame_active <= 1'b1;
              first_row    <= 1'b1;
              row_base     <= '0;
              col          <= '0;
              count        <= '0;
            end
            16'h0001: begin
              if (first_row) begin
                first_row <= 1'b0;
              end else begin
                if (count != '0) flush_pend <= 1'b1;
                row_base <= row_base + ROW_STEP;
                col      <= '0;
              end
            end
            16'hFFFF: begin
              frame_active <= 1'b0;
              if (count != '0) begin
                flush_pend <= 1'b1;
                swap_pend  <= 1'b1;
              end else begin
                display_buf <= wr_buf;
                wr_buf      <= !wr_buf;
                frame_swap  <= 1'b1;
              end
            end
            default: ;
          endcase
        end else if (px_take) begin
          if (count == '0) start_addr <= wr_base + row_base + ADDR_WIDTH'(col);
          count <= count + LEN_W'(1);
          col   <= col + COL_W'(1);
          if (count + LEN_W'(1) == BLEN) flush_pend <= 1'b1;
        end
      end

      case (state)
        ARB_IDLE: begin
          if (flush_pend && (!rd_req_valid || !last_grant_wr)) begin
            state         <= ISSUE_WR;
            last_grant_wr <= 1'b1;
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= 1'b1;
            mem_cmd_addr  <= start_addr;
            mem_cmd_len   <= count;
          end else if (rd_req_valid) begin
            state         <= ISSUE_RD;
            last_grant_wr <= 1'b0;
            mem_cmd_valid <= 1'b1;
            mem_cmd_write <= 1'b0;
            mem_cmd_addr  <= disp_base + rd_req_offset;
            mem_cmd_len   <= rd_req_len;
          end
        end
        ISSUE_WR: begin
          if (mem_cmd_ready) begin
            state           <= STREAM_WR;
            mem_cmd_valid   <= 1'b0;
            mem_wdata       <= pbuf[0];
            mem_wdata_valid <= 1'b1;
            idx             <= '0;
          end
        end
        STREAM_WR: begin
          if (wd_fire) begin
            if (last_word) begin
              state           <= ARB_IDLE;
              mem_wdata_valid <= 1'b0;
              count           <= '0;
              flush_pend      <= 1'b0;
              if (swap_pend) begin
                swap_pend   <= 1'b0;
                display_buf <= wr_buf;
                wr_buf      <= !wr_buf;
                frame_swap  <= 1'b1;
              end
            end else begin
              idx       <= idx_nxt;
              mem_wdata <= pbuf[idx_nxt[IDX_W-1:0]];
            end
          end
        end
        ISSUE_RD: begin
          if (mem_cmd_ready) begin
            state         <= ARB_IDLE;
            mem_cmd_valid <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FB_SCHED_STATS_EN
  logic [15:0]      drop_cnt;
  logic [LEN_W-1:0] drop_amt;
  logic [16:0]      drop_sum;

  always_comb begin
    drop_amt = '0;
    if (queue_rd_en) begin
      if (is_ctrl && queue_data[15:0] == 16'h0000) drop_amt = count;
      else if (!is_ctrl && !px_take)               drop_amt = LEN_W'(1);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_amt);
  end

  always_ff @(posedge MemClk or posedge RST) begin
    if (RST) drop_cnt <= '0;
    else     drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Sits between the camera token queue and the PSRAM memory controller command port.
- Drains 17-bit camera tokens, packs pixels into write bursts and computes frame-buffer addresses.
- Arbitrates the single memory command port between these camera write bursts and display read requests.
- Double-buffers frames (ping-pong) and swaps buffers on frame end.

Parameters:
- FRAME_WIDTH, 640: pixels per row.
- FRAME_HEIGHT, 480: rows per frame.
- BURST_LEN, 16: maximum pixel words per write burst; FRAME_WIDTH multiple of BURST_LEN.
- ADDR_WIDTH, 21: memory word address width.
- FRAME0_BASE, 21'h000000: word base of buffer 0.
- FRAME1_BASE, 21'h080000: word base of buffer 1.

Ports:
- MemClk  in  1  clock; all logic rising-edge.
- RST  in  1  asynchronous, active-high reset.
- queue_data  in  17  FWFT queue head; bit16=1 is control (10000 frame start, 10001 row start, 1FFFF frame end), bit16=0 is pixel [15:0].
- queue_empty  in  1  head invalid when high.
- queue_rd_en  out  1  pop head this cycle.
- mem_cmd_valid  out  1  command valid.
- mem_cmd_ready  in  1  controller accepts command.
- mem_cmd_write  out  1  1 = write, 0 = read.
- mem_cmd_addr  out  ADDR_WIDTH  word address.
- mem_cmd_len  out  $clog2(BURST_LEN)+1  words in burst, 1..BURST_LEN.
- mem_wdata  out  16  write word.
- mem_wdata_valid  out  1  write word valid.
- mem_wdata_ready  in  1  controller takes word.
- rd_req_valid  in  1  display read request.
- rd_req_offset  in  ADDR_WIDTH  word offset within displayed frame.
- rd_req_len  in  $clog2(BURST_LEN)+1  read length.
- rd_req_ready  out  1  display request forwarded (accepted by memory).
- frame_swap  out  1  one-cycle pulse on buffer swap.
- display_buf  out  1  buffer currently displayed.
- drop_count  out  16  dropped-token counter (see Optional Feature).

Behaviour:
- Reset (async, RST high): all outputs 0 except display_buf=1; write buffer=0; pixel buffer empty; frame_active=0; address pointer 0; last_grant=write.
- Token intake, when no flush is pending: queue_rd_en is asserted combinationally when !queue_empty and the pixel buffer holds fewer than BURST_LEN words. One token is consumed per cycle.
- 10000: frame_active=1, row base=0, column=0. Any partial buffer is discarded, and each discarded word counts as a drop.
- 10001, first occurrence after 10000: no-op.
- 10001, later occurrences: a partial buffer is flushed, then row base += FRAME_WIDTH and column=0.
- Pixel with frame_active=1: written to the buffer; column increments. When the column reaches FRAME_WIDTH, further pixels in that row are dropped.
- Pixel with frame_active=0: dropped.
- 1FFFF: a partial buffer is flushed; frame_active=0; then the swap occurs: display_buf<=write buffer, write buffer toggles, frame_swap pulses one cycle after the last wdata handshake, or the cycle after the pop if nothing was buffered.
- Flush trigger: buffer reaches BURST_LEN, or partial flush per the rules above. Intake stalls (queue_rd_en=0) until the burst data is fully streamed.
- Write address = write-buffer base + row base + column of the first buffered word. Width is truncated to ADDR_WIDTH.
- Command arbiter states:
  - ARB_IDLE: select a requester.
  - ISSUE_WR: mem_cmd_valid=1, mem_cmd_write=1; holds until mem_cmd_ready.
  - STREAM_WR: words streamed in order with valid/ready; the value is held while ready=0; returns to ARB_IDLE after word mem_cmd_len.
  - ISSUE_RD: mem_cmd_valid=1, write=0, addr = display base + rd_req_offset; rd_req_ready pulses the cycle mem_cmd_ready is seen.
- Arbitration: if only one requester is pending, it wins. If both are pending, the one not granted last wins (alternate). ISSUE_x is entered the cycle after ARB_IDLE.
- The swap takes effect for read commands issued after the frame_swap cycle. A read in ISSUE_RD keeps its latched address.
- Command outputs are registered and stable while valid=1 and ready=0.

Optional Feature:
- FB_SCHED_STATS_EN defined: drop_count increments (saturating at FFFF) per dropped pixel or discarded buffered word. It clears only on reset.
- Not defined: drop_count is tied to 0 and the counter logic is absent.

Test Plan:
- FRAME_WIDTH=32, FRAME_HEIGHT=2, BURST_LEN=16; tokens 10000, 10001, 32 px, 10001, 32 px, 1FFFF, mem_cmd_ready/wdata_ready always 1 -> four writes at addr 0, 16, 32, 48 (len 16); frame_swap once; display_buf=0.
- Second identical frame -> writes at FRAME1_BASE+0..48; display_buf returns to 1.
- Row of 20 px then 10001 -> write len 16 at 0 and len 4 at 16; next row starts at addr 32.
- rd_req_valid held high during a frame -> commands alternate read/write; read addr = FRAME1_BASE+offset before the first swap.
- mem_wdata_ready toggling 1/0 -> mem_wdata held stable across stalls; no word lost or repeated.
- Pixels before 10000, and 5 extra px beyond FRAME_WIDTH -> no writes; with FB_SCHED_STATS_EN, drop_count equals the dropped total; RST mid-burst -> mem_cmd_valid=0 and mem_wdata_valid=0 immediately.
